// File: rtl/ysyx_23060201_lsu.sv
// ============================================================================
// Module   : ysyx_23060201_lsu
// Purpose  : Load/store unit that turns EXU memory ops into word-aligned
//            memory strobes and returns extended load data to WBU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_23060201_lsu #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LATENCY        = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_is_load,
  input  logic                      in_is_store,
  input  logic [2:0]                in_funct3,
  input  logic [MEM_ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0]     in_wdata,
  output logic                      mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [7:0]                mem_wmask,
  output logic                      mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_rdata,
  output logic                      out_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic       c_HAS_WAIT = (LATENCY != 0);
  localparam logic [3:0] c_LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_is_load;
  logic                      r_err;
  logic [2:0]                r_funct3;
  logic [1:0]                r_off;
  logic [3:0]                r_cnt;
  logic                      r_mem_wen;
  logic                      r_mem_ren;
  logic [3:0]                r_wmask;
  logic [MEM_ADDR_WIDTH-1:0] r_waddr;
  logic [MEM_ADDR_WIDTH-1:0] r_raddr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH-1:0]     r_out_rdata;

  logic [1:0]                w_off;
  logic [MEM_ADDR_WIDTH-1:0] w_word_addr;
  logic                      w_misal;
  logic                      w_illegal;
  logic                      w_err;
  logic                      w_accept;
  logic                      w_do_store;
  logic                      w_do_load;
  logic [3:0]                w_mask;
  logic [DATA_WIDTH-1:0]     w_wdata_sh;
  logic [DATA_WIDTH-1:0]     w_raw;
  logic [DATA_WIDTH-1:0]     w_load_ext;

  assign w_off       = in_addr[1:0];
  assign w_word_addr = {in_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
  assign w_wdata_sh  = in_wdata << {w_off, 3'b000};
  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_do_store  = w_accept && in_is_store && !w_err;
  assign w_do_load   = w_accept && in_is_load && !w_err;

  // funct3[1:0] encodes access size for both loads and stores
  always_comb begin
    w_misal   = 1'b0;
    w_illegal = 1'b0;
    w_mask    = 4'b1111;
    case (in_funct3[1:0])
      2'b00:   w_mask = 4'b0001 << w_off;
      2'b01: begin
        w_mask  = 4'b0011 << w_off;
        w_misal = in_addr[0];
      end
      2'b10:   w_misal = (w_off != 2'b00);
      default: w_mask = 4'b1111;
    endcase
    if (in_is_load) begin
      w_illegal = (in_funct3 == 3'd3) || (in_funct3 == 3'd6) || (in_funct3 == 3'd7);
    end else if (in_is_store) begin
      w_illegal = (in_funct3 > 3'd2);
    end
    w_err = (in_is_load || in_is_store) && (w_illegal || w_misal);
  end

  assign w_raw = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_ext = w_raw;
    case (r_funct3)
      3'd0:    w_load_ext = {{(DATA_WIDTH-8){w_raw[7]}}, w_raw[7:0]};
      3'd1:    w_load_ext = {{(DATA_WIDTH-16){w_raw[15]}}, w_raw[15:0]};
      3'd4:    w_load_ext = {{(DATA_WIDTH-8){1'b0}}, w_raw[7:0]};
      3'd5:    w_load_ext = {{(DATA_WIDTH-16){1'b0}}, w_raw[15:0]};
      default: w_load_ext = w_raw;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = (w_do_store || w_do_load) ? S_ISSUE : S_RESP;
      S_ISSUE: w_next = c_HAS_WAIT ? S_WAIT : S_RESP;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_load   <= 1'b0;
      r_err       <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_cnt       <= 4'd0;
      r_mem_wen   <= 1'b0;
      r_mem_ren   <= 1'b0;
      r_wmask     <= 4'd0;
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_wdata     <= '0;
      r_out_rdata <= '0;
    end else begin
      // Strobes are set only on the accept edge, so they last exactly the ISSUE cycle
      r_mem_wen <= w_do_store;
      r_mem_ren <= w_do_load;
      r_wmask   <= w_do_store ? w_mask : 4'd0;
      if (w_accept) begin
        r_is_load   <= in_is_load;
        r_err       <= w_err;
        r_funct3    <= in_funct3;
        r_off       <= w_off;
        r_out_rdata <= '0;
      end
      if (w_do_store) begin
        r_waddr <= w_word_addr;
        r_wdata <= w_wdata_sh;
      end
      if (w_do_load) r_raddr <= w_word_addr;
      if (r_state == S_ISSUE) begin
        r_cnt <= c_LAT_M1;
        if (r_is_load) r_out_rdata <= w_load_ext;
      end
      if ((r_state == S_WAIT) && (r_cnt != 4'd0)) r_cnt <= r_cnt - 4'd1;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_RESP);
  assign out_rdata = r_out_rdata;
  assign out_err   = r_err;
  assign mem_wen   = r_mem_wen;
  assign mem_ren   = r_mem_ren;
  assign mem_wmask = {4'b0000, r_wmask};
  assign mem_waddr = r_waddr;
  assign mem_wdata = r_wdata;
  assign mem_raddr = r_raddr;

endmodule

`default_nettype wire

// File: doc/ysyx_23060201_lsu.md
# ysyx_23060201_lsu

Load/store unit between the execute stage and the data-memory port of the NPC core. It takes one memory operation per handshake from EXU and issues a single-cycle, word-aligned strobe to the memory port (wen/waddr/wdata/wmask, plus ren/raddr/rdata for loads). It then waits a programmable number of latency cycles and returns the aligned, sign- or zero-extended result to WBU over a valid/ready handshake. It owns all byte-lane alignment, mask generation and misalignment detection so the memory port sees only word-aligned accesses.

## Interface
- MEM_ADDR_WIDTH, 32, address width (byte address)
- DATA_WIDTH, 32, data width; fixed at 32 for RV32
- LATENCY, 0, extra wait cycles after the issue cycle before the response (0..15)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low (one clock domain; polarity and synchronicity fixed)
- in_valid  in  1  EXU presents an operation
- in_ready  out  1  LSU can accept; high only in IDLE
- in_is_load  in  1  operation is a load
- in_is_store  in  1  operation is a store; load and store are never both high
- in_funct3  in  3  RV32 funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2
- in_addr  in  MEM_ADDR_WIDTH  effective byte address
- in_wdata  in  DATA_WIDTH  store source (rs2)
- mem_wen  out  1  write strobe, one cycle per store
- mem_waddr  out  MEM_ADDR_WIDTH  word-aligned write address
- mem_wdata  out  DATA_WIDTH  lane-shifted write data
- mem_wmask  out  8  byte mask; bits [7:4] always 0
- mem_ren  out  1  read strobe, one cycle per load
- mem_raddr  out  MEM_ADDR_WIDTH  word-aligned read address
- mem_rdata  in  DATA_WIDTH  read word, valid combinationally in the mem_ren cycle
- out_valid  out  1  response available to WBU
- out_ready  in  1  WBU accepts the response
- out_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors
- out_err  out  1  misaligned access or illegal funct3

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: in_ready=1. On in_valid, latch addr, funct3, wdata and op type, and compute err. If err is set, or neither load nor store is set, go to RESP. Otherwise go to ISSUE.
- ISSUE (one cycle):
  - Store: mem_wen=1.
  - Load: mem_ren=1, and the extended result is registered from mem_rdata.
  - Next state is WAIT if LATENCY>0, else RESP. The counter loads LATENCY-1.
- WAIT: count down; go to RESP when the counter is 0.
- RESP: out_valid=1. out_rdata and out_err stay stable until out_ready. On out_valid&out_ready, go to IDLE.
- Address: waddr = raddr = {addr[MSB:2], 2'b00}. off = addr[1:0].
- Store mask:
  - SB: 4'b0001<<off
  - SH: 4'b0011<<off
  - SW: 4'b1111
- Store data: wdata << (8*off), truncated to 32 bits.
- Load: raw = mem_rdata >> (8*off).
  - LB: sign-extend raw[7:0]
  - LBU: zero-extend raw[7:0]
  - LH: sign-extend raw[15:0]
  - LHU: zero-extend raw[15:0]
  - LW: raw
- Errors:
  - H-type access with addr[0]=1.
  - W-type access with off!=0.
  - Load funct3 in {3,6,7}, or store funct3 >2.
  - On error: no mem_wen/mem_ren is issued, out_err=1, out_rdata=0, and the response follows the normal handshake.
- When mem_wen and mem_ren are both 0, waddr/wdata/mask/raddr hold their last values. mem_wmask is forced to 0 whenever mem_wen=0.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - mem_wen=0, mem_ren=0, mem_wmask=0
  - mem_waddr=0, mem_wdata=0, mem_raddr=0
  - out_valid=0, out_rdata=0, out_err=0
- Counter resets to 0.
- Accept at edge T:
  - Memory op: strobe in cycle T+1; out_valid first high in cycle T+2+LATENCY.
  - Error or non-memory op: out_valid in cycle T+1.
- Throughput: at most one op in flight. in_ready=0 from ISSUE through RESP, so no new op is accepted in the same cycle as a response handshake. The next accept is possible in the cycle after the handshake.
- Backpressure: while out_ready=0 in RESP, the state and all out_* hold indefinitely, and no further memory strobe occurs.
- Reset asserted mid-operation (any state) has immediate effect:
  - all strobes and out_valid drop asynchronously;
  - the pending op is discarded and is never replayed.
- Strobes are exactly one cycle wide and registered.

## Test plan
- Byte store, LATENCY=0: SB, addr 0x80000003, wdata 0x12345678, accepted at cycle 0.
  - Cycle 1: mem_wen=1, waddr=0x80000000, wdata=0x78000000, wmask=0x08.
  - Cycle 2: out_valid=1, out_err=0.
- Halfword loads: mem_rdata=0x80017FFF, addr 0x80000002.
  - LH: out_rdata=0xFFFF8001.
  - LHU: out_rdata=0x00008001.
  - LB at addr 0x80000000: out_rdata=0xFFFFFFFF.
- Misaligned store: SW, addr 0x80000002.
  - mem_wen is never asserted.
  - Next cycle: out_valid=1, out_err=1, out_rdata=0.
- Latency: LATENCY=3, LW accepted at cycle 0.
  - mem_ren only in cycle 1, raddr word-aligned.
  - out_valid at cycle 5 with out_rdata=mem_rdata sampled in cycle 1.
- Backpressure: out_ready held 0 for 4 cycles in RESP.
  - out_valid and out_rdata are stable and in_ready=0.
  - in_valid presented meanwhile is not accepted until the cycle after the handshake.
- Reset in WAIT: assert rst_n=0 with LATENCY=5 during WAIT.
  - Outputs go to reset values immediately.
  - After release: in_ready=1 and no out_valid for the dropped op.
